// File: rtl/alarm_buzzer_ctrl.sv
// Alarm buzzer controller: turns a level alarm request into a gated beep with snooze, dismiss and timeout.
// Optional feature macro: ALARM_ESCALATE_EN (continuous tone after ESCALATE_SEC ringing seconds).
module alarm_buzzer_ctrl #(
    parameter int BEEP_PERIOD  = 1000,
    parameter int SNOOZE_SEC   = 300,
    parameter int TIMEOUT_SEC  = 60,
    parameter int MAX_SNOOZE   = 3,
    parameter int ESCALATE_SEC = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trigger,
    input  logic       sec_tick,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       buzzer_out,
    output logic       ringing,
    output logic       snoozed,
    output logic [3:0] snooze_count
);

    localparam int BW = (BEEP_PERIOD > 2) ? $clog2(BEEP_PERIOD) : 1;
    localparam int RW = (TIMEOUT_SEC > 2) ? $clog2(TIMEOUT_SEC) : 1;
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC + 1) : 1;

    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_PERIOD - 1);
    localparam logic [BW-1:0] BEEP_HALF = BW'(BEEP_PERIOD / 2);
    localparam logic [RW-1:0] RING_LAST = RW'(TIMEOUT_SEC - 1);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SEC);
    localparam logic [SW-1:0] SNZ_ONE   = SW'(1);
    localparam logic [3:0]    SNZ_MAX   = 4'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic [RW-1:0] ring_sec_q, ring_sec_d;
    logic [SW-1:0] snz_sec_q, snz_sec_d;
    logic [3:0]    snooze_count_q, snooze_count_d;
    logic          buzzer_q, buzzer_d;
    logic          ringing_q, ringing_d;
    logic          snoozed_q, snoozed_d;
    logic          escalated_s;

    // State, counters and registered outputs; async reset silences the buzzer at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            beep_cnt_q     <= '0;
            ring_sec_q     <= '0;
            snz_sec_q      <= '0;
            snooze_count_q <= 4'd0;
            buzzer_q       <= 1'b0;
            ringing_q      <= 1'b0;
            snoozed_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            beep_cnt_q     <= beep_cnt_d;
            ring_sec_q     <= ring_sec_d;
            snz_sec_q      <= snz_sec_d;
            snooze_count_q <= snooze_count_d;
            buzzer_q       <= buzzer_d;
            ringing_q      <= ringing_d;
            snoozed_q      <= snoozed_d;
        end
    end

    // Next-state and counter update; a dropped trigger outranks every other event.
    always_comb begin
        state_d        = state_q;
        beep_cnt_d     = beep_cnt_q;
        ring_sec_d     = ring_sec_q;
        snz_sec_d      = snz_sec_q;
        snooze_count_d = snooze_count_q;
        if (!trigger) begin
            state_d        = ST_IDLE;
            beep_cnt_d     = '0;
            ring_sec_d     = '0;
            snz_sec_d      = '0;
            snooze_count_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_RING;
                    beep_cnt_d = '0;
                    ring_sec_d = '0;
                end
                ST_RING: begin
                    if (dismiss) begin
                        state_d = ST_DONE;
                    end else if (sec_tick && (ring_sec_q == RING_LAST)) begin
                        state_d = ST_DONE;
                    end else if (snooze && (snooze_count_q < SNZ_MAX)) begin
                        state_d        = ST_SNOOZE;
                        snooze_count_d = snooze_count_q + 4'd1;
                        snz_sec_d      = SNZ_LOAD;
                    end else begin
                        beep_cnt_d = (beep_cnt_q == BEEP_LAST) ? '0 : beep_cnt_q + BW'(1);
                        ring_sec_d = sec_tick ? ring_sec_q + RW'(1) : ring_sec_q;
                    end
                end
                ST_SNOOZE: begin
                    if (dismiss) begin
                        state_d = ST_DONE;
                    end else if (sec_tick && (snz_sec_q == SNZ_ONE)) begin
                        state_d    = ST_RING;
                        beep_cnt_d = '0;
                        ring_sec_d = '0;
                    end else if (sec_tick) begin
                        snz_sec_d = snz_sec_q - SW'(1);
                    end else begin
                        snz_sec_d = snz_sec_q;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so registered outputs track the transition.
    always_comb begin
`ifdef ALARM_ESCALATE_EN
        escalated_s = ({{(32-RW){1'b0}}, ring_sec_d} >= $unsigned(32'(ESCALATE_SEC)));
`else
        escalated_s = 1'b0;
`endif
        ringing_d = (state_d == ST_RING);
        snoozed_d = (state_d == ST_SNOOZE);
        buzzer_d  = (state_d == ST_RING) && ((beep_cnt_d < BEEP_HALF) || escalated_s);
    end

    assign buzzer_out   = buzzer_q;
    assign ringing      = ringing_q;
    assign snoozed      = snoozed_q;
    assign snooze_count = snooze_count_q;

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Directed self-checking bench for alarm_buzzer_ctrl with small parameters.
module tb_alarm_buzzer_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       trigger, sec_tick, snooze, dismiss;
    logic       buzzer_out, ringing, snoozed;
    logic [3:0] snooze_count;
    logic [6:0] obs, exp_v;
    int         n_cmp = 0;
    int         n_err = 0;

    alarm_buzzer_ctrl #(
        .BEEP_PERIOD (4),
        .SNOOZE_SEC  (3),
        .TIMEOUT_SEC (5),
        .MAX_SNOOZE  (2),
        .ESCALATE_SEC(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .trigger     (trigger),
        .sec_tick    (sec_tick),
        .snooze      (snooze),
        .dismiss     (dismiss),
        .buzzer_out  (buzzer_out),
        .ringing     (ringing),
        .snoozed     (snoozed),
        .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    assign obs = {ringing, snoozed, buzzer_out, snooze_count};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic press_snooze();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; trigger = 1'b0; sec_tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        #12;
        n_cmp++;
        if (obs !== 7'b0) begin
            n_err++;
            $display("FAIL reset_state got=%b want=%b", obs, 7'b0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) step();
        n_cmp++;
        if (obs !== 7'b0) begin
            n_err++;
            $display("FAIL idle_no_trigger got=%b want=%b", obs, 7'b0);
        end
    endtask

    task automatic test_ring();
        trigger = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_v = {1'b1, 1'b0, ((k % 4) < 2), 4'd0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL ring_pattern k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_snooze();
        press_snooze();
        n_cmp++;
        if (obs !== {1'b0, 1'b1, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL snooze_enter got=%b want=%b", obs, {1'b0, 1'b1, 1'b0, 4'd1});
        end
        tick();
        tick();
        n_cmp++;
        if (obs !== {1'b0, 1'b1, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL snooze_hold got=%b want=%b", obs, {1'b0, 1'b1, 1'b0, 4'd1});
        end
        tick();
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b1, 4'd1}) begin
            n_err++;
            $display("FAIL snooze_resume got=%b want=%b", obs, {1'b1, 1'b0, 1'b1, 4'd1});
        end
        step();
        step();
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL resume_gate got=%b want=%b", obs, {1'b1, 1'b0, 1'b0, 4'd1});
        end
    endtask

    task automatic test_max_snooze_timeout();
        press_snooze();
        tick(); tick(); tick();
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b1, 4'd2}) begin
            n_err++;
            $display("FAIL second_resume got=%b want=%b", obs, {1'b1, 1'b0, 1'b1, 4'd2});
        end
        press_snooze();
        n_cmp++;
        if ({ringing, snoozed, snooze_count} !== {1'b1, 1'b0, 4'd2}) begin
            n_err++;
            $display("FAIL snooze_limit got=%b want=%b", {ringing, snoozed, snooze_count}, {1'b1, 1'b0, 4'd2});
        end
        tick(); tick(); tick(); tick();
        n_cmp++;
        if ({ringing, snoozed} !== 2'b10) begin
            n_err++;
            $display("FAIL pre_timeout got=%b want=%b", {ringing, snoozed}, 2'b10);
        end
        tick();
        n_cmp++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd2}) begin
            n_err++;
            $display("FAIL timeout_done got=%b want=%b", obs, {1'b0, 1'b0, 1'b0, 4'd2});
        end
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd2}) begin
            n_err++;
            $display("FAIL done_hold got=%b want=%b", obs, {1'b0, 1'b0, 1'b0, 4'd2});
        end
        trigger = 1'b0;
        step();
        n_cmp++;
        if (obs !== 7'b0) begin
            n_err++;
            $display("FAIL done_to_idle got=%b want=%b", obs, 7'b0);
        end
    endtask

    task automatic test_snooze_dismiss();
        trigger = 1'b1;
        step();
        press_snooze();
        tick(); tick(); tick();
        snooze = 1'b1; dismiss = 1'b1;
        step();
        snooze = 1'b0; dismiss = 1'b0;
        n_cmp++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL snooze_dismiss got=%b want=%b", obs, {1'b0, 1'b0, 1'b0, 4'd1});
        end
        trigger = 1'b0;
        step();
    endtask

    task automatic test_trigger_drop();
        trigger = 1'b1;
        step();
        press_snooze();
        trigger = 1'b0;
        step();
        n_cmp++;
        if (obs !== 7'b0) begin
            n_err++;
            $display("FAIL drop_in_snooze got=%b want=%b", obs, 7'b0);
        end
        trigger = 1'b1;
        step();
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL ring_before_reset got=%b want=%b", obs, {1'b1, 1'b0, 1'b1, 4'd0});
        end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({ringing, buzzer_out} !== 2'b00) begin
            n_err++;
            $display("FAIL async_reset got=%b want=%b", {ringing, buzzer_out}, 2'b00);
        end
        trigger = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_escalate();
        trigger = 1'b1;
        step();
        tick();
        tick();
`ifdef ALARM_ESCALATE_EN
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++;
            if (buzzer_out !== 1'b1) begin
                n_err++;
                $display("FAIL escalate_const k=%0d got=%b want=1", k, buzzer_out);
            end
        end
        press_snooze();
        tick(); tick(); tick();
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (buzzer_out !== ((k % 4) < 2)) begin
                n_err++;
                $display("FAIL escalate_reset_pattern k=%0d got=%b want=%b", k, buzzer_out, ((k % 4) < 2));
            end
            step();
        end
`else
        // Two ticks consumed beep slots 1 and 2; no escalation means the gated pattern continues.
        for (int k = 3; k < 9; k++) begin
            step();
            n_cmp++;
            if (buzzer_out !== ((k % 4) < 2)) begin
                n_err++;
                $display("FAIL no_escalate k=%0d got=%b want=%b", k, buzzer_out, ((k % 4) < 2));
            end
        end
`endif
        trigger = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_ring();
        test_snooze();
        test_max_snooze_timeout();
        test_snooze_dismiss();
        test_trigger_drop();
        test_escalate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_buzzer_ctrl.md
Name: alarm_buzzer_ctrl

Overview:
Sits directly downstream of the alarm comparator and consumes its level-type buzzer request (t_main >= t_alarm while armed). Turns that level into a gated beep pattern with snooze, dismiss and auto-timeout handling. Drives the physical buzzer pin and status LEDs. Fully synchronous to the system clock, except for the asynchronous reset.

Parameters:
BEEP_PERIOD, 1000, clk cycles per beep period; buzzer_out is high for the first BEEP_PERIOD/2 cycles. Must be even and >= 2.
SNOOZE_SEC, 300, seconds spent in SNOOZE before ringing resumes.
TIMEOUT_SEC, 60, seconds of continuous ringing before automatic silence.
MAX_SNOOZE, 3, maximum snoozes per alarm event (1..15).
ESCALATE_SEC, 10, ringing seconds before escalation; used only with ALARM_ESCALATE_EN.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
trigger  input  1  level buzzer request from the alarm stage (timer_buzzer)
sec_tick  input  1  one-clk pulse per second from the timebase
snooze  input  1  one-clk debounced snooze press
dismiss  input  1  one-clk debounced dismiss press
buzzer_out  output  1  buzzer drive
ringing  output  1  high in RING
snoozed  output  1  high in SNOOZE
snooze_count  output  4  snoozes used in the current alarm event

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; all counters 0; buzzer_out=0, ringing=0, snoozed=0, snooze_count=0. Reset asserted mid-ring silences the buzzer immediately, without waiting for a clock edge.
- States: IDLE, RING, SNOOZE, DONE. Registered transitions, one clk each.
- Priority each cycle: trigger low > dismiss > timeout > snooze > counting.
- From any non-IDLE state, trigger low means next state is IDLE. On this transition snooze_count clears and all counters clear.
- IDLE: trigger high means next state is RING. ring_sec=0 and beep_cnt=0.
- RING:
  - beep_cnt counts 0..BEEP_PERIOD-1 and wraps.
  - buzzer_out = (beep_cnt < BEEP_PERIOD/2). It is therefore high on the first RING cycle.
  - ring_sec increments on each sec_tick.
  - dismiss means next state is DONE.
  - If ring_sec==TIMEOUT_SEC-1 and sec_tick, next state is DONE (timeout).
  - If snooze and snooze_count<MAX_SNOOZE, next state is SNOOZE. snooze_count increments and snz_sec loads SNOOZE_SEC.
  - If snooze and snooze_count==MAX_SNOOZE, the snooze is ignored and the alarm stays in RING.
  - If snooze and dismiss arrive in the same cycle, dismiss wins.
- SNOOZE:
  - buzzer_out=0.
  - snz_sec decrements on sec_tick.
  - If snz_sec==1 and sec_tick, next state is RING. ring_sec and beep_cnt reset to 0.
  - dismiss means next state is DONE.
  - snooze presses are ignored.
- DONE: buzzer_out=0. Waits for trigger low, then goes to IDLE. This prevents re-ringing while the upstream level stays high.
- Outputs are registered; buzzer_out, ringing and snoozed update one clk after the state-change condition.
- A sec_tick in the same cycle as entering RING or SNOOZE is not counted.
- Counters are sized with $clog2 of their maximum value and never wrap outside the ranges above.

Optional Feature:
ALARM_ESCALATE_EN
- Defined: once ring_sec >= ESCALATE_SEC within a RING episode, buzzer_out stays continuously high (beep gating off) until RING is left. Each re-entry to RING from SNOOZE restarts in beeping mode.
- Undefined: buzzer_out is always the gated beep pattern in RING. ESCALATE_SEC is unused.

Test Plan:
(Parameters for all scenarios: BEEP_PERIOD=4, SNOOZE_SEC=3, TIMEOUT_SEC=5, MAX_SNOOZE=2, ESCALATE_SEC=2.)
1. trigger rises at cycle 10 -> ringing=1 from cycle 11; buzzer_out pattern 1,1,0,0 repeating; snooze_count=0.
2. In RING, pulse snooze -> snoozed=1, buzzer_out=0, snooze_count=1. After 3 sec_ticks -> ringing=1 again with buzzer_out=1 on the first RING cycle.
3. Snooze twice (with full waits), then press snooze a third time -> stays in RING, snooze_count=2. Then 5 sec_ticks -> DONE, buzzer_out=0. Holding trigger high keeps the block in DONE; dropping trigger -> IDLE, snooze_count=0.
4. snooze and dismiss in the same cycle during RING -> DONE, snooze_count unchanged.
5. trigger drops while in SNOOZE -> IDLE next clk, all outputs 0. Separately, reset_n low mid-RING -> buzzer_out=0 immediately (asynchronous).
6. With ALARM_ESCALATE_EN defined: after 2 sec_ticks in RING -> buzzer_out constant 1. After snooze and return to RING -> gated pattern 1,1,0,0 resumes.
